// File: rtl/coherency_watch_ctrl.sv
// Coherency watch controller: arms a batch of consecutive cache lines, snoops
// invalidations, waits out a (optionally exponential) backoff, then notifies.
//
// state     | meaning
// S_IDLE    | ready for a new batch, no lines armed
// S_ARMED   | lines armed, waiting for the first matching invalidation
// S_BACKOFF | counting down the backoff window; matches reload the counter
// S_NOTIFY  | notification pending, mask frozen until handshake
module coherency_watch_ctrl #(
  parameter int LINE_NUM      = 4,
  parameter int ADDR_WIDTH    = 40,
  parameter int LINE_OFFSET   = 6,
  parameter int BACKOFF_WIDTH = 16,
  parameter int SIZE_W        = $clog2(LINE_NUM) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     watch_valid_i,
  output logic                     watch_ready_o,
  input  logic [ADDR_WIDTH-1:0]    watch_base_i,
  input  logic [SIZE_W-1:0]        watch_size_i,
  input  logic [BACKOFF_WIDTH-1:0] backoff_i,
  input  logic                     exp_mode_i,
  input  logic                     cancel_i,
  input  logic                     inv_valid_i,
  input  logic [ADDR_WIDTH-1:0]    inv_addr_i,
  output logic                     notify_valid_o,
  input  logic                     notify_ready_i,
  output logic [LINE_NUM-1:0]      notify_mask_o,
  output logic                     busy_o
);

  localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_BACKOFF = 2'd2,
    S_NOTIFY  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [LINE_W-1:0]        base_line_q, base_line_d;
  logic [LINE_NUM-1:0]      valid_q, valid_d;
  logic [LINE_NUM-1:0]      mask_q, mask_d;
  logic [BACKOFF_WIDTH-1:0] cnt_q, cnt_d;
  logic [BACKOFF_WIDTH-1:0] cur_q, cur_d;
  logic [BACKOFF_WIDTH-1:0] base_bo_q, base_bo_d;
  logic                     exp_q, exp_d;

  logic [LINE_NUM-1:0]      hit_vec;
  logic                     any_hit;
  logic [BACKOFF_WIDTH-1:0] cur_grow;
  logic [LINE_W-1:0]        inv_line;

  // Sub-line offset bits never participate in matching.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{watch_base_i[LINE_OFFSET-1:0], inv_addr_i[LINE_OFFSET-1:0]};

  assign inv_line = inv_addr_i[ADDR_WIDTH-1:LINE_OFFSET];

  // Entry addresses wrap modulo the line address space.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < LINE_NUM; i++) begin
      hit_vec[i] = inv_valid_i && valid_q[i] && (inv_line == base_line_q + LINE_W'(i));
    end
  end

  assign any_hit = |hit_vec;

  always_comb begin
    if (cur_q == '0)                     cur_grow = BACKOFF_WIDTH'(1);
    else if (cur_q[BACKOFF_WIDTH-1])     cur_grow = '1;
    else                                 cur_grow = {cur_q[BACKOFF_WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    base_line_d = base_line_q;
    valid_d     = valid_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    base_bo_d   = base_bo_q;
    exp_d       = exp_q;
    case (state_q)
      S_IDLE: begin
        if (watch_valid_i && (watch_size_i != '0)) begin
          base_line_d = watch_base_i[ADDR_WIDTH-1:LINE_OFFSET];
          exp_d       = exp_mode_i;
          cur_d       = backoff_i;
          base_bo_d   = backoff_i;
          mask_d      = '0;
          for (int i = 0; i < LINE_NUM; i++) begin
            valid_d[i] = (SIZE_W'(i) < watch_size_i);
          end
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cancel_i) begin
          valid_d = '0;
          mask_d  = '0;
          state_d = S_IDLE;
        end else if (any_hit) begin
          mask_d  = mask_q | hit_vec;
          cnt_d   = cur_q;
          state_d = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        if (cancel_i) begin
          valid_d = '0;
          mask_d  = '0;
          state_d = S_IDLE;
        end else if (any_hit) begin
          mask_d = mask_q | hit_vec;
          if (exp_q) begin
            cur_d = cur_grow;
            cnt_d = cur_grow;
          end else begin
            cnt_d = cur_q;
          end
        end else if (cnt_q == '0) begin
          state_d = S_NOTIFY;
        end else begin
          cnt_d = cnt_q - BACKOFF_WIDTH'(1);
        end
      end
      S_NOTIFY: begin
        if (notify_ready_i) begin
          valid_d = '0;
          mask_d  = '0;
          cur_d   = base_bo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      base_line_q <= '0;
      valid_q     <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      base_bo_q   <= '0;
      exp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_line_q <= base_line_d;
      valid_q     <= valid_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      base_bo_q   <= base_bo_d;
      exp_q       <= exp_d;
    end
  end

  assign watch_ready_o  = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign notify_valid_o = (state_q == S_NOTIFY);
  assign notify_mask_o  = mask_q;

endmodule

// File: tb/tb_coherency_watch_ctrl.sv
// Bench for coherency_watch_ctrl: deadline-based reference model checked every
// cycle, plus directed scenarios with hand-computed latencies and masks.
module tb_coherency_watch_ctrl;
  localparam int LN = 4;
  localparam int AW = 40;
  localparam int LO = 6;
  localparam int BW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          watch_valid_i = 1'b0;
  logic          watch_ready_o;
  logic [AW-1:0] watch_base_i = '0;
  logic [SW-1:0] watch_size_i = '0;
  logic [BW-1:0] backoff_i = '0;
  logic          exp_mode_i = 1'b0;
  logic          cancel_i = 1'b0;
  logic          inv_valid_i = 1'b0;
  logic [AW-1:0] inv_addr_i = '0;
  logic          notify_valid_o;
  logic          notify_ready_i = 1'b0;
  logic [LN-1:0] notify_mask_o;
  logic          busy_o;

  int n_cmp = 0;
  int n_fail = 0;

  coherency_watch_ctrl #(.LINE_NUM(LN), .ADDR_WIDTH(AW), .LINE_OFFSET(LO),
                         .BACKOFF_WIDTH(BW), .SIZE_W(SW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .watch_valid_i(watch_valid_i), .watch_ready_o(watch_ready_o),
    .watch_base_i(watch_base_i), .watch_size_i(watch_size_i),
    .backoff_i(backoff_i), .exp_mode_i(exp_mode_i), .cancel_i(cancel_i),
    .inv_valid_i(inv_valid_i), .inv_addr_i(inv_addr_i),
    .notify_valid_o(notify_valid_o), .notify_ready_i(notify_ready_i),
    .notify_mask_o(notify_mask_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase 0=idle, 1=watching, 2=notify; notification time is
  // tracked as an absolute deadline cycle rather than a counter.
  longint cyc = 0;
  bit     m_init = 0;
  int     m_phase = 0;
  longint m_base = 0;
  int     m_n = 0;
  int     m_mask = 0;
  int     m_cur = 0;
  int     m_bo = 0;
  bit     m_exp = 0;
  longint m_dl = -1;

  always @(posedge clk) begin
    longint line;
    int hits;
    int load;
    line = longint'(inv_addr_i[AW-1:LO]);
    if (rst_i) begin
      m_init = 1; m_phase = 0; m_mask = 0; m_cur = 0; m_bo = 0; m_n = 0; m_dl = -1;
    end else begin
      case (m_phase)
        0: if (watch_valid_i && watch_size_i != 0) begin
             m_base  = longint'(watch_base_i[AW-1:LO]);
             m_n     = (int'(watch_size_i) > LN) ? LN : int'(watch_size_i);
             m_mask  = 0;
             m_cur   = int'(backoff_i);
             m_bo    = int'(backoff_i);
             m_exp   = exp_mode_i;
             m_dl    = -1;
             m_phase = 1;
           end
        1: begin
          hits = 0;
          if (inv_valid_i)
            for (int i = 0; i < m_n; i++)
              if (line == ((m_base + i) % (64'd1 << (AW - LO)))) hits |= (1 << i);
          if (cancel_i) begin
            m_phase = 0; m_mask = 0; m_dl = -1;
          end else if (hits != 0) begin
            m_mask |= hits;
            if (m_dl >= 0 && m_exp)
              m_cur = (m_cur == 0) ? 1 : ((2 * m_cur > 65535) ? 65535 : 2 * m_cur);
            load = m_cur;
            m_dl = cyc + load + 2;
          end else if (m_dl >= 0 && cyc + 1 == m_dl) begin
            m_phase = 2;
          end
        end
        default: if (notify_ready_i) begin
          m_phase = 0; m_mask = 0; m_cur = m_bo; m_dl = -1;
        end
      endcase
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_ready",  watch_ready_o,  m_phase == 0);
      chk("model_busy",   busy_o,         m_phase != 0);
      chk("model_nvalid", notify_valid_o, m_phase == 2);
      chk("model_mask",   notify_mask_o,  m_mask[LN-1:0]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic arm(input logic [AW-1:0] base, input int size, input int b, input bit e);
    watch_valid_i = 1; watch_base_i = base; watch_size_i = SW'(size);
    backoff_i = BW'(b); exp_mode_i = e;
    tick();
    watch_valid_i = 0;
  endtask

  task automatic inval(input logic [AW-1:0] a);
    inv_valid_i = 1; inv_addr_i = a;
    tick();
    inv_valid_i = 0;
  endtask

  task automatic wait_notify(output int n, input int start);
    n = start;
    while (!notify_valid_o && n < 60) begin tick(); n++; end
  endtask

  task automatic handshake();
    notify_ready_i = 1;
    tick();
    notify_ready_i = 0;
  endtask

  initial begin
    int n;
    int seen;
    tick(); tick();
    chk("rst_ready", watch_ready_o, 1);
    chk("rst_nvalid", notify_valid_o, 0);
    chk("rst_mask", notify_mask_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 0;
    tick();

    // fixed-mode basic hit
    arm(40'h1000, 2, 3, 0);
    chk("basic_busy", busy_o, 1);
    inval(40'h1044);
    wait_notify(n, 1);
    chk("basic_latency", n, 5);
    chk("basic_mask", notify_mask_o, 4'b0010);
    handshake();
    chk("basic_ready_after", watch_ready_o, 1);

    // exponential growth: hits at t and t+2
    arm(40'h2000, 1, 4, 1);
    inval(40'h2000);
    tick();
    inval(40'h2010);
    wait_notify(n, 3);
    chk("exp_latency", n, 12);
    handshake();
    arm(40'h2000, 1, 4, 1);
    inval(40'h2000);
    wait_notify(n, 1);
    chk("exp_restart_latency", n, 6);
    handshake();

    // B=0 exponential, second hit lands on counter==0 and reloads 1
    arm(40'h3000, 1, 0, 1);
    inval(40'h3000);
    inval(40'h3000);
    wait_notify(n, 2);
    chk("exp_zero_latency", n, 4);
    chk("exp_zero_mask", notify_mask_o, 4'b0001);
    handshake();

    // clamp: size 7 arms 4 entries; base+4 misses, base+3 hits
    arm(40'h4000, 7, 1, 0);
    inval(40'h4100);
    tick(); tick();
    chk("clamp_miss_busy", busy_o, 1);
    chk("clamp_miss_nvalid", notify_valid_o, 0);
    inval(40'h40C0);
    wait_notify(n, 1);
    chk("clamp_latency", n, 3);
    chk("clamp_mask", notify_mask_o, 4'b1000);
    handshake();

    // wrap: base line all-ones, size 2, line 0 is entry 1
    arm(40'hFF_FFFF_FFC0, 2, 2, 0);
    inval(40'h15);
    wait_notify(n, 1);
    chk("wrap_latency", n, 4);
    chk("wrap_mask", notify_mask_o, 4'b0010);
    handshake();

    // miss at base+size, then hit, then ignored inval during NOTIFY
    arm(40'h1000, 2, 3, 0);
    inval(40'h1080);
    tick(); tick(); tick();
    chk("miss_busy", busy_o, 1);
    chk("miss_mask", notify_mask_o, 0);
    inval(40'h1000);
    wait_notify(n, 1);
    chk("miss_then_hit_latency", n, 5);
    inval(40'h1040);
    chk("notify_ignore_mask", notify_mask_o, 4'b0001);
    handshake();

    // size 0 is a no-op
    arm(40'h5000, 0, 3, 0);
    chk("size0_busy", busy_o, 0);
    chk("size0_ready", watch_ready_o, 1);

    // cancel in BACKOFF
    arm(40'h6000, 4, 10, 0);
    inval(40'h6000);
    tick();
    cancel_i = 1;
    tick();
    cancel_i = 0;
    chk("cancel_bo_busy", busy_o, 0);
    chk("cancel_bo_mask", notify_mask_o, 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (notify_valid_o) seen++; end
    chk("cancel_no_notify", seen, 0);

    // cancel beats same-cycle match in ARMED
    arm(40'h6000, 4, 2, 0);
    cancel_i = 1; inv_valid_i = 1; inv_addr_i = 40'h6040;
    tick();
    cancel_i = 0; inv_valid_i = 0;
    chk("cancel_arm_busy", busy_o, 0);
    chk("cancel_arm_mask", notify_mask_o, 0);

    // backpressure then reset while notify pending
    arm(40'h7000, 2, 0, 0);
    inval(40'h7040);
    wait_notify(n, 1);
    chk("bp_latency", n, 2);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_nvalid", notify_valid_o, 1);
      chk("bp_mask", notify_mask_o, 4'b0010);
    end
    rst_i = 1;
    tick();
    rst_i = 0;
    chk("rst_pend_nvalid", notify_valid_o, 0);
    chk("rst_pend_ready", watch_ready_o, 1);
    chk("rst_pend_busy", busy_o, 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/coherency_watch_ctrl.md
# coherency_watch_ctrl

Parametrised coherency watch controller for the Cohort tile. It arms a batch of up to LINE_NUM consecutive cache lines and snoops the invalidation stream for writes to them. On a hit it waits out a programmable backoff window, optionally growing it exponentially while invalidations keep arriving, and then raises a single notification carrying a per-line hit mask. It generalises the fixed 4-line / 16-bit-backoff watcher with configurable depth, line size, address width and backoff mode, plus cancel and hit-mask reporting.

## Interface
Parameters:
- LINE_NUM, 4, maximum lines watched per batch (≥1)
- ADDR_WIDTH, 40, physical address width
- LINE_OFFSET, 6, log2 of line size in bytes
- BACKOFF_WIDTH, 16, backoff counter width
- SIZE_W, $clog2(LINE_NUM)+1, width of the batch size field

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- watch_valid_i  in  1  arm request
- watch_ready_o  out  1  request accepted when high together with valid
- watch_base_i  in  ADDR_WIDTH  first line address; low LINE_OFFSET bits are ignored
- watch_size_i  in  SIZE_W  number of lines to watch
- backoff_i  in  BACKOFF_WIDTH  base backoff, in cycles
- exp_mode_i  in  1  1 selects exponential backoff growth
- cancel_i  in  1  abandon the current batch
- inv_valid_i  in  1  invalidation observed
- inv_addr_i  in  ADDR_WIDTH  invalidation address
- notify_valid_o  out  1  notification pending
- notify_ready_i  in  1  consumer accepts the notification
- notify_mask_o  out  LINE_NUM  entries hit; bit i is line base+i
- busy_o  out  1  state is not IDLE

## Operation
- The FSM has four states: IDLE, ARMED, BACKOFF and NOTIFY. Reset value is IDLE.
- **IDLE**
  - watch_ready_o=1.
  - On accept, the controller latches the line base (watch_base_i[ADDR_WIDTH-1:LINE_OFFSET]), exp_mode_i and backoff_i. backoff_i is stored in both cur_q and base_q.
  - The effective size is min(watch_size_i, LINE_NUM). Entries 0..size-1 are marked valid and the hit mask is cleared.
  - Size 0 is accepted, has no effect, and the state stays IDLE. Otherwise the next state is ARMED.
- **Entry line address**: entry i has line address base+i, computed modulo 2^(ADDR_WIDTH-LINE_OFFSET), so wrap-around past the top of memory is legal.
- **Match**: inv_valid_i=1 and inv_addr_i[ADDR_WIDTH-1:LINE_OFFSET] equals the line address of a valid entry. That entry's mask bit is set; the set bit is sticky.
- **ARMED**
  - On a match: the counter loads cur_q and the next state is BACKOFF.
  - Non-matching invalidations are ignored.
- **BACKOFF**
  - With no match, the counter decrements by 1 each cycle. When counter==0, the next state is NOTIFY.
  - On a match with exp_mode=1:
    - cur_q is updated to nxt = (cur_q==0) ? 1 : min(2·cur_q, 2^BACKOFF_WIDTH−1), saturating.
    - The counter loads nxt.
  - On a match with exp_mode=0: the counter reloads cur_q.
  - A match in the same cycle as counter==0: the reload wins and the FSM stays in BACKOFF.
- **NOTIFY**
  - notify_valid_o=1 and notify_mask_o is held stable until the handshake completes.
  - On notify_valid_o & notify_ready_i: entries are cleared, cur_q is restored to base_q, and the next state is IDLE.
  - Invalidations are ignored in NOTIFY.
- **cancel_i**
  - In ARMED or BACKOFF: next state is IDLE, entries and mask are cleared, no notification is issued. cancel_i beats a same-cycle match.
  - In IDLE and NOTIFY, cancel_i is ignored.
- **Reset**: rst_i in any state, including mid-backoff or with notify pending, returns the block to IDLE and drops any pending notification.
- **Outputs after reset**: watch_ready_o=1, notify_valid_o=0, notify_mask_o=0, busy_o=0. The counter, cur_q and base_q reset to 0.
- notify_mask_o is the registered mask in every state; it reads 0 in IDLE.

## Timing
- All outputs are registered from state and the mask register; there are no combinational input-to-output paths.
- watch_ready_o depends only on state.
- Accept at cycle t: ARMED and busy_o=1 at t+1. An invalidation at t+1 can already match.
- Match in ARMED at cycle t with backoff B: BACKOFF at t+1 with counter=B, and notify_valid_o=1 at cycle t+B+2.
  - B=0 gives notify at t+2.
- A reloading match in BACKOFF at cycle t with load value L gives notify at t+L+2, provided no further match occurs.
- Notify handshake at cycle t: IDLE and watch_ready_o=1 at t+1. A new batch is accepted no earlier than t+1.
- Throughput: one batch in flight at a time.

## Test plan
- **Fixed-mode basic hit**: arm base 0x1000, size 2, B=3, exp=0; inval 0x1044 at t → notify_valid at t+5, mask=2'b10; handshake → IDLE, watch_ready=1.
- **Exponential growth**: B=4, exp=1; matching invals at t and at t+2 → counter reloads 8 at t+3, notify at t+12; next batch starts again from B=4. Also B=0, exp=1, two hits → second load is 1.
- **Clamp and wrap**: size 7 with LINE_NUM=4 → only 4 entries are armed. Base line = all-ones, size 2 → inval to line 0 sets mask bit 1.
- **Miss and ignore**: inval to line base+size while ARMED → no state change. Inval during NOTIFY → mask unchanged. Size 0 → stays IDLE, busy=0.
- **Cancel**: cancel in BACKOFF → IDLE next cycle, notify never asserts, mask=0. cancel together with a match in ARMED → IDLE.
- **Reset and backpressure**: hold notify_ready=0 for 10 cycles → valid and mask stay stable. rst_i while notify pending → next cycle notify_valid=0, watch_ready=1, busy=0.
